// File: rtl/timer_ctrl.sv
// Programmable timer: prescaled up-counter with compare match, one-shot or auto-reload,
// configured through a single-cycle memory-mapped register port.
//
// state | meaning
// IDLE  | counter and prescaler hold, waiting for EN
// RUN   | prescaler advances every cycle, counter steps on each tick
// DONE  | one-shot match reached, everything holds until software acts
module timer_ctrl #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        running
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_n;
    logic                 ctrl_en, ctrl_auto, ctrl_ie;
    logic [PRESC_W-1:0]   presc, pcnt;
    logic [WIDTH-1:0]     cmp, count;
    logic                 match;

    logic wr, wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
    logic tick_raw, tick, match_tick, inc;
    logic unused_addr;

    assign unused_addr = ^addr[1:0];

    assign wr        = sel & we;
    assign wr_ctrl   = wr && (addr[4:2] == 3'd0);
    assign wr_presc  = wr && (addr[4:2] == 3'd1);
    assign wr_cmp    = wr && (addr[4:2] == 3'd2);
    assign wr_count  = wr && (addr[4:2] == 3'd3);
    assign wr_status = wr && (addr[4:2] == 3'd4);

    // A COUNT write or a stopping CTRL write in the tick cycle swallows the tick.
    assign tick_raw   = (state == RUN) && (pcnt == presc);
    assign tick       = tick_raw && !wr_count && !(wr_ctrl && !wdata[0]);
    assign match_tick = tick && (count == cmp);
    assign inc        = tick && (count != cmp);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (wr_ctrl && wdata[0]) state_n = RUN;
            RUN: begin
                if (wr_ctrl && !wdata[0])                      state_n = IDLE;
                else if (match_tick && !ctrl_auto && !wr_ctrl) state_n = DONE;
            end
            DONE: begin
                if (wr_ctrl)                       state_n = wdata[0] ? RUN : IDLE;
                else if (wr_status && wdata[0])    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
            presc     <= '0;
            cmp       <= '0;
            count     <= '0;
            pcnt      <= '0;
            match     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= wdata[0];
                ctrl_auto <= wdata[1];
                ctrl_ie   <= wdata[2];
            end else if (match_tick && !ctrl_auto) begin
                ctrl_en <= 1'b0;
            end

            if (wr_presc) presc <= PRESC_W'(wdata);
            if (wr_cmp)   cmp   <= WIDTH'(wdata);

            if (wr_count)                              pcnt <= '0;
            else if (wr_ctrl && wdata[0] && state != RUN) pcnt <= '0;
            else if (state == RUN)                     pcnt <= tick_raw ? '0 : pcnt + PRESC_W'(1);

            if (wr_count)                     count <= WIDTH'(wdata);
            else if (match_tick && ctrl_auto) count <= '0;
            else if (inc)                     count <= count + WIDTH'(1);

            // A new match beats a simultaneous software clear.
            if (match_tick)                 match <= 1'b1;
            else if (wr_status && wdata[0]) match <= 1'b0;
        end
    end

    assign irq = match & ctrl_ie;

    always_comb begin
        rdata = '0;
        if (sel && !we) begin
            case (addr[4:2])
                3'd0:    rdata = {29'b0, ctrl_ie, ctrl_auto, ctrl_en};
                3'd1:    rdata = 32'(presc);
                3'd2:    rdata = 32'(cmp);
                3'd3:    rdata = 32'(count);
                3'd4:    rdata = {31'b0, match};
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: reads push expected values into a scoreboard,
// a negedge monitor pops and compares rdata/irq/running on every bus read.
module tb_timer_ctrl;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_PRESC  = 5'h04;
    localparam logic [4:0] A_CMP    = 5'h08;
    localparam logic [4:0] A_COUNT  = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;

    logic        clk = 1'b0;
    logic        rst, sel, we;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;
    logic        irq, running;

    always #5 clk = ~clk;

    timer_ctrl #(.WIDTH(32), .PRESC_W(16)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .running(running)
    );

    typedef struct {
        string       name;
        logic [31:0] d;
        logic        irq;
        logic        run;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;

    always @(negedge clk) begin
        if (!rst && sel && !we) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_read: addr=%h got rdata=%h, required no read", addr, rdata);
            end else begin
                mon_e = sb.pop_front();
                if ({rdata, irq, running} !== {mon_e.d, mon_e.irq, mon_e.run}) begin
                    tests_failed++;
                    $display("FAIL %s: got rdata=%h irq=%b running=%b, required rdata=%h irq=%b running=%b",
                             mon_e.name, rdata, irq, running, mon_e.d, mon_e.irq, mon_e.run);
                end
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic i,
                      input logic r, input string n);
        exp_t e;
        e.name = n; e.d = d; e.irq = i; e.run = r;
        sb.push_back(e);
        sel = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset values and unmapped space
        rd(A_CTRL,   32'h0, 1'b0, 1'b0, "rst_ctrl");
        rd(A_PRESC,  32'h0, 1'b0, 1'b0, "rst_presc");
        rd(A_CMP,    32'h0, 1'b0, 1'b0, "rst_cmp");
        rd(A_COUNT,  32'h0, 1'b0, 1'b0, "rst_count");
        rd(A_STATUS, 32'h0, 1'b0, 1'b0, "rst_status");
        rd(5'h14,    32'h0, 1'b0, 1'b0, "rst_unmapped");
        wr(5'h14, 32'hFFFF_FFFF);
        wr(5'h18, 32'hFFFF_FFFF);
        rd(A_CTRL,   32'h0, 1'b0, 1'b0, "unmapped_wr_ctrl");
        rd(A_COUNT,  32'h0, 1'b0, 1'b0, "unmapped_wr_count");
        wr(A_PRESC, 32'hFFFF_FFFF);
        rd(A_PRESC,  32'h0000_FFFF, 1'b0, 1'b0, "presc_trunc");

        // one-shot with IE, PRESC=0, CMP=5
        wr(A_PRESC, 32'h0);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h5);
        for (int i = 0; i < 6; i++) rd(A_COUNT, 32'(i), 1'b0, 1'b1, "oneshot_count");
        rd(A_STATUS, 32'h1, 1'b1, 1'b0, "oneshot_match");
        rd(A_CTRL,   32'h4, 1'b1, 1'b0, "oneshot_ctrl_en_clr");
        idle(20);
        rd(A_COUNT,  32'd5, 1'b1, 1'b0, "oneshot_hold");

        // auto-reload, PRESC=3, CMP=2 -> period 12
        wr(A_STATUS, 32'h1);
        wr(A_CTRL, 32'h0);
        wr(A_COUNT, 32'h0);
        wr(A_PRESC, 32'd3);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 12; i++) rd(A_COUNT, 32'(i / 4), 1'b0, 1'b1, "auto_count");
        rd(A_STATUS, 32'h1, 1'b0, 1'b1, "auto_match1");
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, 32'h0, 1'b0, 1'b1, "auto_clear");
        idle(8);
        rd(A_STATUS, 32'h0, 1'b0, 1'b1, "auto_pre_match2");
        rd(A_STATUS, 32'h1, 1'b0, 1'b1, "auto_match2");
        rd(A_COUNT,  32'h0, 1'b0, 1'b1, "auto_reload");
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);

        // counter wrap from all-ones
        wr(A_PRESC, 32'h0);
        wr(A_CMP, 32'd3);
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        rd(A_COUNT, 32'hFFFF_FFFF, 1'b0, 1'b1, "wrap_start");
        for (int i = 0; i < 4; i++) rd(A_COUNT, 32'(i), 1'b0, 1'b1, "wrap_count");
        rd(A_STATUS, 32'h1, 1'b0, 1'b0, "wrap_match");
        rd(A_COUNT,  32'd3, 1'b0, 1'b0, "wrap_hold");

        // collisions in auto mode, PRESC=0
        wr(A_STATUS, 32'h1);
        wr(A_COUNT, 32'h0);
        wr(A_CMP, 32'h20);
        wr(A_CTRL, 32'h3);
        idle(2);
        wr(A_COUNT, 32'h10);
        rd(A_COUNT, 32'h10, 1'b0, 1'b1, "count_wr_vs_tick");
        rd(A_COUNT, 32'h11, 1'b0, 1'b1, "count_after_wr");
        idle(13);
        rd(A_COUNT, 32'h1F, 1'b0, 1'b1, "count_pre_match");
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, 32'h1, 1'b0, 1'b1, "set_beats_clear");
        rd(A_COUNT,  32'h1, 1'b0, 1'b1, "count_after_reload");

        // reset mid-count, with a simultaneous CMP write
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        wr(A_CMP, 32'h100);
        wr(A_COUNT, 32'h0);
        wr(A_CTRL, 32'h5);
        idle(7);
        rd(A_COUNT, 32'd7, 1'b0, 1'b1, "pre_rst_count");
        rst = 1'b1; sel = 1'b1; we = 1'b1; addr = A_CMP; wdata = 32'h55;
        @(posedge clk); #1;
        rst = 1'b0; sel = 1'b0; we = 1'b0;
        rd(A_CTRL,   32'h0, 1'b0, 1'b0, "midrst_ctrl");
        rd(A_PRESC,  32'h0, 1'b0, 1'b0, "midrst_presc");
        rd(A_CMP,    32'h0, 1'b0, 1'b0, "midrst_cmp");
        rd(A_COUNT,  32'h0, 1'b0, 1'b0, "midrst_count");
        rd(A_STATUS, 32'h0, 1'b0, 1'b0, "midrst_status");
        idle(5);
        rd(A_COUNT,  32'h0, 1'b0, 1'b0, "midrst_no_count");

        idle(2);
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
